// File: rtl/n64_flashram_pkg.sv
// Shared definitions for the N64 FlashRAM save-chip controller.
//   state_t       : controller state machine encoding
//   CMD_*         : command opcodes, found in bus_wdata[31:24] of a command-register write
//   SILICON_ID    : word returned at status offset 0x4 when N64_FLASHRAM_SILICON_ID_EN is defined
//   STATUS_ID_HI  : upper 24 bits returned with the status nibble at offset 0x0 in that build
package n64_flashram_pkg;

  typedef enum logic [2:0] {
    ST_STATUS,
    ST_READ,
    ST_ERASE,
    ST_WRITE_BUFFER,
    ST_BUSY
  } state_t;

  localparam logic [7:0] CMD_STATUS       = 8'hE1;
  localparam logic [7:0] CMD_READ         = 8'hF0;
  localparam logic [7:0] CMD_SECTOR_ERASE = 8'h4B;
  localparam logic [7:0] CMD_CHIP_ERASE   = 8'h3C;
  localparam logic [7:0] CMD_ERASE_MODE   = 8'h78;
  localparam logic [7:0] CMD_WRITE_BUF    = 8'hB4;
  localparam logic [7:0] CMD_PROGRAM      = 8'hA5;
  localparam logic [7:0] CMD_EXECUTE      = 8'hD2;

  localparam logic [31:0] SILICON_ID   = 32'h00C2_001E;
  localparam logic [23:0] STATUS_ID_HI = 24'h111180;

endpackage

// File: rtl/n64_flashram_ctrl.sv
// N64 FlashRAM controller: decodes PI register-bus accesses into FlashRAM
// commands, streams page-buffer writes to the save-memory backend and
// hands erase/program jobs to the scb side through a pending/done handshake.
//
// Optional build macro: N64_FLASHRAM_SILICON_ID_EN -- when defined, status
// reads in STATUS return the silicon ID at offset 0x4 and an ID-tagged
// status word at offset 0x0.
//
// Ports
//   clk, reset_n                : clock, asynchronous active-low reset
//   bus_req/bus_write/bus_cmd_sel/bus_address/bus_wdata : PI register access
//   bus_rdata, bus_ack          : read data and ack, one cycle after bus_req
//   flashram_enabled            : controller enable from the cartridge config
//   flashram_done               : completion pulse for the pending job
//   flashram_pending            : erase/program job outstanding
//   flashram_page, flashram_sector_or_all, flashram_write_or_erase : job descriptor
//   flashram_read_mode          : controller sits in READ
//   flashram_write/_address/_wdata : one-cycle page-buffer word write
module n64_flashram_ctrl
  import n64_flashram_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_req,
  input  logic        bus_write,
  input  logic        bus_cmd_sel,
  input  logic [6:0]  bus_address,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        flashram_enabled,
  input  logic        flashram_done,
  output logic        flashram_pending,
  output logic [9:0]  flashram_page,
  output logic        flashram_sector_or_all,
  output logic        flashram_write_or_erase,
  output logic        flashram_read_mode,
  output logic        flashram_write,
  output logic [5:0]  flashram_address,
  output logic [15:0] flashram_wdata
);

  state_t      state;
  logic        op_valid;
  logic        write_done;
  logic        erase_done;
  logic [3:0]  status;
  logic        cmd_wr;
  logic        data_wr;
  logic        data_rd;
  logic        exec_ok;
  logic [7:0]  opcode;
  logic [31:0] read_value;
  logic        unused_bits;

  // write_or_erase doubles as the "selected op is erase" flag
  assign status = {erase_done, write_done,
                   (state == ST_BUSY) && op_valid &&  flashram_write_or_erase,
                   (state == ST_BUSY) && op_valid && !flashram_write_or_erase};

  // Disabled controller: accesses are still acked but have no effect
  assign cmd_wr  = bus_req && flashram_enabled &&  bus_write &&  bus_cmd_sel;
  assign data_wr = bus_req && flashram_enabled &&  bus_write && !bus_cmd_sel;
  assign data_rd = bus_req && flashram_enabled && !bus_write && !bus_cmd_sel;
  assign opcode  = bus_wdata[31:24];

  // Execute only fires when the mode matches the selected operation
  assign exec_ok = ((state == ST_ERASE)        && op_valid &&  flashram_write_or_erase) ||
                   ((state == ST_WRITE_BUFFER) && op_valid && !flashram_write_or_erase);

  assign unused_bits = ^{bus_address[0], bus_wdata[23:16]};

  always_comb begin
    read_value = 32'd0;
`ifdef N64_FLASHRAM_SILICON_ID_EN
    if (state == ST_STATUS)
      read_value = bus_address[2] ? SILICON_ID : {STATUS_ID_HI, 4'd0, status};
    else if (state == ST_BUSY)
      read_value = {28'd0, status};
`else
    if (state == ST_STATUS || state == ST_BUSY)
      read_value = {28'd0, status};
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= ST_STATUS;
      op_valid                <= 1'b0;
      write_done              <= 1'b0;
      erase_done              <= 1'b0;
      bus_ack                 <= 1'b0;
      bus_rdata               <= 32'd0;
      flashram_pending        <= 1'b0;
      flashram_page           <= 10'd0;
      flashram_sector_or_all  <= 1'b0;
      flashram_write_or_erase <= 1'b0;
      flashram_read_mode      <= 1'b0;
      flashram_write          <= 1'b0;
      flashram_address        <= 6'd0;
      flashram_wdata          <= 16'd0;
    end else begin
      bus_ack            <= bus_req;
      bus_rdata          <= data_rd ? read_value : 32'd0;
      flashram_write     <= 1'b0;
      flashram_read_mode <= (state == ST_READ);

      if (!flashram_enabled && state != ST_BUSY)
        state <= ST_STATUS;

      if (state == ST_BUSY) begin
        // Pending trails BUSY entry by one cycle; bus traffic is ignored here
        if (flashram_done) begin
          flashram_pending        <= 1'b0;
          state                   <= ST_STATUS;
          op_valid                <= 1'b0;
          flashram_write_or_erase <= 1'b0;
          flashram_sector_or_all  <= 1'b0;
          if (flashram_write_or_erase) erase_done <= 1'b1;
          else                         write_done <= 1'b1;
        end else begin
          flashram_pending <= 1'b1;
        end
      end else if (cmd_wr) begin
        case (opcode)
          CMD_STATUS:     state <= ST_STATUS;
          CMD_READ:       state <= ST_READ;
          CMD_ERASE_MODE: state <= ST_ERASE;
          CMD_WRITE_BUF: begin
            state                   <= ST_WRITE_BUFFER;
            op_valid                <= 1'b0;
            flashram_write_or_erase <= 1'b0;
            flashram_sector_or_all  <= 1'b0;
          end
          CMD_SECTOR_ERASE: begin
            op_valid                <= 1'b1;
            flashram_write_or_erase <= 1'b1;
            flashram_sector_or_all  <= 1'b0;
            flashram_page           <= {bus_wdata[9:7], 7'd0};
          end
          CMD_CHIP_ERASE: begin
            op_valid                <= 1'b1;
            flashram_write_or_erase <= 1'b1;
            flashram_sector_or_all  <= 1'b1;
            flashram_page           <= 10'd0;
          end
          CMD_PROGRAM: begin
            op_valid                <= 1'b1;
            flashram_write_or_erase <= 1'b0;
            flashram_sector_or_all  <= 1'b0;
            flashram_page           <= bus_wdata[9:0];
          end
          CMD_EXECUTE: if (exec_ok) state <= ST_BUSY;
          default: ;
        endcase
      end else if (data_wr) begin
        if (state == ST_WRITE_BUFFER) begin
          flashram_write   <= 1'b1;
          flashram_address <= bus_address[6:1];
          flashram_wdata   <= bus_wdata[15:0];
        end else if (state == ST_STATUS) begin
          write_done <= 1'b0;
          erase_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/n64_flashram_ctrl.md
N64_FLASHRAM_CTRL -- requirements
Module: n64_flashram_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-002 SHALL have these PI register-bus ports: bus_req in 1 access strobe; bus_write in 1 write/read; bus_cmd_sel in 1 (1=command reg, 0=status/buffer); bus_address in 7 byte offset; bus_wdata in 32; bus_rdata out 32; bus_ack out 1.
REQ-003 SHALL have these scb-side ports: flashram_enabled in 1; flashram_done in 1 (completion pulse); flashram_pending out 1; flashram_page out 10; flashram_sector_or_all out 1 (0=sector, 1=chip); flashram_write_or_erase out 1 (0=program, 1=erase); flashram_read_mode out 1.
REQ-004 SHALL have these buffer-write ports: flashram_write out 1 (one-cycle pulse); flashram_address out 6 (16-bit word index); flashram_wdata out 16.

Function
REQ-005 SHALL implement state machine STATUS, READ, ERASE, WRITE_BUFFER, BUSY.
REQ-006 SHALL assert bus_ack exactly 1 cycle after every bus_req, in every state, and never otherwise.
REQ-007 SHALL decode command writes on bus_wdata[31:24]; page = bus_wdata[9:0].
REQ-008 0xE1 -> STATUS; 0xF0 -> READ; 0x78 -> ERASE; 0xB4 -> WRITE_BUFFER and clear selected op.
REQ-009 0x4B -> select erase, sector_or_all=0, page = bus_wdata[9:7]<<7; 0x3C -> select erase, sector_or_all=1, page=0; 0xA5 -> select program, page.
REQ-010 0xD2 -> BUSY only if (ERASE and erase selected) or (WRITE_BUFFER and program selected); otherwise no state change.
REQ-011 Unknown commands: acked, no effect.
REQ-012 On entering BUSY, flashram_pending SHALL rise on the cycle after the 0xD2 ack and stay high until the cycle after flashram_done.
REQ-013 On flashram_done in BUSY: pending low, selected op cleared, state -> STATUS, set erase_done or write_done per op type.
REQ-014 In BUSY, all command writes and buffer writes SHALL be acked and ignored; flashram_done outside BUSY ignored.
REQ-015 In WRITE_BUFFER, a non-command write SHALL pulse flashram_write for 1 cycle with flashram_address=bus_address[6:1], flashram_wdata=bus_wdata[15:0]; addresses wrap within 64 words.
REQ-016 Status bits: [0] write busy, [1] erase busy, [2] write_done, [3] erase_done; a non-command write in STATUS clears [3:2].
REQ-017 Non-command read in STATUS or BUSY SHALL return {28'd0, status}; in READ, ERASE, WRITE_BUFFER, returns 0.
REQ-018 flashram_read_mode = (state == READ), registered.
REQ-019 flashram_page, sector_or_all, write_or_erase SHALL hold stable while pending is high.
REQ-020 flashram_enabled low: accesses acked, rdata 0, no state change; if not BUSY, state forced to STATUS; an active BUSY completes normally.

Reset
REQ-021 reset_n low: state STATUS, status 0, op cleared, all outputs 0, including bus_ack, bus_rdata, flashram_write.
REQ-022 Reset mid-BUSY SHALL drop pending immediately; any subsequent stray flashram_done SHALL be ignored.

Configuration
REQ-023 Macro N64_FLASHRAM_SILICON_ID_EN defined: in STATUS, non-command read with bus_address[2]=1 returns 0x00C2001E, and with bus_address[2]=0 returns {24'h111180, 4'd0, status}.
REQ-024 Macro not defined: both offsets return per REQ-017; no ID logic is synthesized.

Structure
REQ-025 The state enum, command opcode constants (0xE1, 0xF0, 0x4B, 0x3C, 0x78, 0xB4, 0xA5, 0xD2) and the silicon ID constant SHALL live in shared package n64_flashram_pkg.
REQ-026 Single module; no sub-module is required.

Verification
REQ-027 Sector erase: cmd 0x4B000085, 0x78000000, 0xD2000000 -> pending=1, page=0x080, sector_or_all=0, write_or_erase=1; done pulse -> pending=0, status read=0x8.
REQ-028 Program: cmd 0xB4000000; data writes addr 0x00 wdata 0xBEEF and addr 0x7E wdata 0x1234 -> write pulses at word 0 and word 63; 0xA5000123, 0xD2000000 -> page=0x123, write_or_erase=0; done -> status=0x4.
REQ-029 Illegal execute: 0xD2000000 from STATUS with no selection -> no pending, state unchanged; 0x3C then 0xD2 without 0x78 -> no pending.
REQ-030 Busy lockout: during pending, 0xF0 and buffer writes -> acked, read_mode stays 0, no flashram_write pulses; status read=0x2 during erase.
REQ-031 Reset mid-BUSY: reset_n low for 2 cycles -> pending=0, status=0; later flashram_done -> no change.
REQ-032 ID (macro on): STATUS read at addr 0x4 -> 0x00C2001E; at addr 0x0 after erase -> 0x11118008.
